// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline hazard control unit. Produces the stall/flush commands for the PC,
// IF_ID and ID_EX registers from three events: data-memory wait states,
// branches taken in EX, and load-use dependencies between EX and ID.
// Priority is mem_wait > branch > load_use, so the pipeline registers never
// see a stall and a flush that contradict each other.
//
// A small two-state FSM measures consecutive memory-wait cycles and raises a
// sticky mem_timeout flag. Three saturating counters record stall cycles,
// branch flushes and load-use bubbles.
//
// Ports:
//   clk              system clock, rising edge
//   reset            synchronous, active-high reset
//   id_Rs1, id_Rs2   source register indices of the instruction in ID
//   id_uses_rs2      instruction in ID reads rs2
//   ex_rd            destination register index of the instruction in EX
//   ex_mem_read      instruction in EX is a load
//   ex_branch_taken  branch/jump resolved taken in EX this cycle
//   mem_req          MEM stage has an active data-memory access
//   mem_ready        data memory completes the access this cycle
//   pc_stall         hold PC
//   if_id_stall      hold IF_ID
//   if_id_flush      zero IF_ID
//   id_ex_stall      hold ID_EX
//   id_ex_flush      zero ID_EX (insert bubble)
//   mem_timeout      sticky: memory wait reached TIMEOUT cycles
//   stall_cycles     saturating count of cycles with pc_stall high
//   flush_count      saturating count of branch flush events
//   bubble_count     saturating count of load-use bubbles
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int CNT_W   = 32,
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_Rs1,
    input  logic [4:0]       id_Rs2,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             id_ex_flush,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic [CNT_W-1:0] bubble_count
);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [TO_W-1:0] WAIT_MAX  = '1;
    localparam logic [TO_W-1:0] TO_LIMIT  = TO_W'(TIMEOUT);

    state_t          state, state_next;
    logic [TO_W-1:0] wait_cnt, wait_cnt_next;
    logic            timeout_set;

    logic mem_wait;
    logic load_use;
    logic bubble;

    // -------------------------------------------------------------------------
    // Hazard detection and command arbitration (purely combinational)
    // -------------------------------------------------------------------------
    assign mem_wait = mem_req & ~mem_ready;

    // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
    assign load_use = ex_mem_read & (ex_rd != 5'd0) &
                      ((ex_rd == id_Rs1) | (id_uses_rs2 & (ex_rd == id_Rs2)));

    // A taken branch makes the ID instruction wrong-path, so its load-use
    // dependency is irrelevant: flush it instead of stalling for it.
    assign bubble = load_use & ~ex_branch_taken & ~mem_wait;

    assign pc_stall    = mem_wait | (load_use & ~ex_branch_taken);
    assign if_id_stall = pc_stall;
    assign id_ex_stall = mem_wait;

    // ID_EX gives flush priority over stall, so flushes must be held off while
    // memory is waiting. The frozen pipeline keeps ex_branch_taken stable, so
    // the flush lands in the cycle mem_ready arrives.
    assign if_id_flush = ex_branch_taken & ~mem_wait;
    assign id_ex_flush = (ex_branch_taken | load_use) & ~mem_wait;

    // -------------------------------------------------------------------------
    // Memory-wait FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_next    = state;
        wait_cnt_next = wait_cnt;

        unique case (state)
            RUN: begin
                if (mem_wait) begin
                    state_next    = MEM_WAIT;
                    wait_cnt_next = TO_W'(1);
                end
            end
            MEM_WAIT: begin
                if (mem_wait) begin
                    if (wait_cnt != WAIT_MAX) begin
                        wait_cnt_next = wait_cnt + TO_W'(1);
                    end
                end else begin
                    state_next    = RUN;
                    wait_cnt_next = '0;
                end
            end
            default: begin
                state_next    = RUN;
                wait_cnt_next = '0;
            end
        endcase

        // Flag the cycle in which the running wait count reaches TIMEOUT while
        // the access is still outstanding.
        timeout_set = mem_wait & (wait_cnt_next >= TO_LIMIT);
    end

    // -------------------------------------------------------------------------
    // Memory-wait FSM: state register and sticky timeout
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples values from before this edge, independent of statement order.
        if (reset) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (timeout_set) begin
                mem_timeout <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Saturating performance counters
    // -------------------------------------------------------------------------
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value,
                                                 input logic             en);
        if (en && (value != {CNT_W{1'b1}})) begin
            return value + CNT_W'(1);
        end
        return value;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
            bubble_count <= '0;
        end else begin
            stall_cycles <= sat_inc(stall_cycles, pc_stall);
            flush_count  <= sat_inc(flush_count,  if_id_flush);
            bubble_count <= sat_inc(bubble_count, bubble);
        end
    end

endmodule
